// File: rtl/alu_issue_pkg.sv
// Shared ALU encodings and RV32I ALU-class decode constants for the issue stage.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpSll  = 4'd2,
    OpSlt  = 4'd3,
    OpSltu = 4'd4,
    OpXor  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpOr   = 4'd8,
    OpAnd  = 4'd9
  } op_sel_e;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [1:0] {ASelZero, ASelRs1, ASelPc} a_sel_e;
  typedef enum logic [1:0] {BSelZero, BSelRs2, BSelImm} b_sel_e;

  typedef struct packed {
    op_sel_e     op_sel;
    logic [31:0] opd_a;
    logic [31:0] opd_b;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  localparam entry_t EntryRst = '{op_sel: OpAdd, opd_a: '0, opd_b: '0, rd: '0, illegal: 1'b0};

  // Base (funct7 = 0) operation for a funct3 value.
  function automatic op_sel_e f3_to_op(input logic [2:0] f3);
    op_sel_e op;
    unique case (f3)
      3'd0:    op = OpAdd;
      3'd1:    op = OpSll;
      3'd2:    op = OpSlt;
      3'd3:    op = OpSltu;
      3'd4:    op = OpXor;
      3'd5:    op = OpSrl;
      3'd6:    op = OpOr;
      default: op = OpAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-class decoder: operation, operand selects, immediate, legality.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr_i,
  output op_sel_e     op_sel_o,
  output a_sel_e      a_sel_o,
  output b_sel_e      b_sel_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_sh;
  logic [31:0] imm_u;
  logic        legal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_sh = {27'b0, instr_i[24:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};

  always_comb begin
    op_sel_o = OpAdd;
    a_sel_o  = ASelZero;
    b_sel_o  = BSelZero;
    imm_o    = '0;
    legal    = 1'b0;
    case (opcode)
      OpcOp: begin
        a_sel_o  = ASelRs1;
        b_sel_o  = BSelRs2;
        op_sel_o = f3_to_op(funct3);
        if (funct7 == F7Base) begin
          legal = 1'b1;
        end else if (funct7 == F7Alt && funct3 == 3'd0) begin
          legal    = 1'b1;
          op_sel_o = OpSub;
        end else if (funct7 == F7Alt && funct3 == 3'd5) begin
          legal    = 1'b1;
          op_sel_o = OpSra;
        end
      end
      OpcOpImm: begin
        a_sel_o  = ASelRs1;
        b_sel_o  = BSelImm;
        op_sel_o = f3_to_op(funct3);
        imm_o    = imm_i;
        if (funct3 == 3'd1) begin
          imm_o = imm_sh;
          legal = (funct7 == F7Base);
        end else if (funct3 == 3'd5) begin
          imm_o = imm_sh;
          legal = (funct7 == F7Base) || (funct7 == F7Alt);
          if (funct7 == F7Alt) op_sel_o = OpSra;
        end else begin
          legal = 1'b1;
        end
      end
      OpcLui: begin
        b_sel_o = BSelImm;
        imm_o   = imm_u;
        legal   = 1'b1;
      end
      OpcAuipc: begin
        a_sel_o = ASelPc;
        b_sel_o = BSelImm;
        imm_o   = imm_u;
        legal   = 1'b1;
      end
      default: ;
    endcase
    // Illegal instructions still flow downstream, but as an inert ADD 0,0 to x0.
    if (!legal) begin
      op_sel_o = OpAdd;
      a_sel_o  = ASelZero;
      b_sel_o  = BSelZero;
      imm_o    = '0;
    end
  end

  assign illegal_o = ~legal;
  assign rd_o      = legal ? instr_i[11:7] : 5'd0;

endmodule

// File: rtl/alu_issue.sv
// Register-to-ALU issue stage: decode, writeback forwarding and a two-entry skid
// buffer presenting stable operands to the combinational ALU.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_en,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] opdA,
  output logic [XLEN-1:0] opdB,
  output logic [3:0]      op_sel,
  output logic [4:0]      rd,
  output logic            illegal
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;

  op_sel_e         dec_op;
  a_sel_e          dec_a_sel;
  b_sel_e          dec_b_sel;
  logic [31:0]     dec_imm;
  logic [4:0]      dec_rd;
  logic            dec_illegal;
  logic [XLEN-1:0] rs1_val, rs2_val;
  entry_t          new_entry;
  logic            accept;

  alu_issue_decode u_decode (
    .instr_i   (instr),
    .op_sel_o  (dec_op),
    .a_sel_o   (dec_a_sel),
    .b_sel_o   (dec_b_sel),
    .imm_o     (dec_imm),
    .rd_o      (dec_rd),
    .illegal_o (dec_illegal)
  );

  // Writeback result bypasses the register file; x0 is never forwarded.
  assign rs1_val = (fwd_en && fwd_rd != 5'd0 && fwd_rd == instr[19:15]) ? fwd_data : rs1_data;
  assign rs2_val = (fwd_en && fwd_rd != 5'd0 && fwd_rd == instr[24:20]) ? fwd_data : rs2_data;

  always_comb begin
    new_entry         = EntryRst;
    new_entry.op_sel  = dec_op;
    new_entry.rd      = dec_rd;
    new_entry.illegal = dec_illegal;
    unique case (dec_a_sel)
      ASelRs1: new_entry.opd_a = rs1_val;
      ASelPc:  new_entry.opd_a = pc;
      default: new_entry.opd_a = '0;
    endcase
    unique case (dec_b_sel)
      BSelRs2: new_entry.opd_b = rs2_val;
      BSelImm: new_entry.opd_b = dec_imm;
      default: new_entry.opd_b = '0;
    endcase
  end

  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            out_d   = new_entry;
          end
        end
        StOne: begin
          if (accept && out_ready) begin
            out_d = new_entry;
          end else if (accept) begin
            skid_d  = new_entry;
            state_d = StTwo;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_ready) begin
            out_d   = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      out_q   <= EntryRst;
      skid_q  <= EntryRst;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign opdA      = out_q.opd_a;
  assign opdB      = out_q.opd_b;
  assign op_sel    = out_q.op_sel;
  assign rd        = out_q.rd;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed literal checks plus randomized traffic against a
// queue-based model of the issue stage.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        fwd_en = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [31:0] fwd_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] opdA, opdB;
  logic [3:0]  op_sel;
  logic [4:0]  rd;
  logic        illegal;

  alu_issue #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .fwd_en    (fwd_en),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opdA      (opdA),
    .opdB      (opdB),
    .op_sel    (op_sel),
    .rd        (rd),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t model_q[$];
  bit   post_rst = 1'b0;

  function automatic logic [3:0] op_for(input logic [2:0] f3, input bit alt);
    logic [3:0] base [8];
    base = '{OpAdd, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpOr, OpAnd};
    if (alt && f3 == 3'd0) return OpSub;
    if (alt && f3 == 3'd5) return OpSra;
    return base[f3];
  endfunction

  // What the ALU must see for one instruction, straight from the RV32I field rules.
  function automatic exp_t ref_issue(input logic [31:0] ins, input logic [31:0] r1,
                                     input logic [31:0] r2, input logic [31:0] pcv);
    exp_t e;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    bit ok = 1'b0;
    e = '{op: OpAdd, a: 32'd0, b: 32'd0, rd: ins[11:7], ill: 1'b0};
    if (opc == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.op = op_for(f3, f7 == 7'h20);
      e.a = r1;
      e.b = r2;
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1) ok = (f7 == 7'h00);
      else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
      else ok = 1'b1;
      e.op = op_for(f3, f3 == 3'd5 && f7 == 7'h20);
      e.a = r1;
      e.b = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
    end else if (opc == 7'h37) begin
      ok = 1'b1;
      e.b = {ins[31:12], 12'd0};
    end else if (opc == 7'h17) begin
      ok = 1'b1;
      e.a = pcv;
      e.b = {ins[31:12], 12'd0};
    end
    if (!ok) e = '{op: OpAdd, a: 32'd0, b: 32'd0, rd: 5'd0, ill: 1'b1};
    return e;
  endfunction

  // Model: an in-order queue of at most two instructions; head is what the ALU sees.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        model_q.delete();
        post_rst = 1'b1;
      end else if (flush) begin
        model_q.delete();
      end else begin
        bit acc, pop;
        logic [31:0] r1, r2;
        acc = in_valid && (model_q.size() < 2);
        pop = (model_q.size() > 0) && out_ready;
        r1 = (fwd_en && fwd_rd != 0 && fwd_rd == instr[19:15]) ? fwd_data : rs1_data;
        r2 = (fwd_en && fwd_rd != 0 && fwd_rd == instr[24:20]) ? fwd_data : rs2_data;
        if (pop) void'(model_q.pop_front());
        if (acc) begin
          model_q.push_back(ref_issue(instr, r1, r2, pc));
          post_rst = 1'b0;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
      if (model_q.size() != 0) begin
        chk("op_sel", {28'd0, op_sel}, {28'd0, model_q[0].op});
        chk("opdA", opdA, model_q[0].a);
        chk("opdB", opdB, model_q[0].b);
        chk("rd", {27'd0, rd}, {27'd0, model_q[0].rd});
        chk("illegal", {31'd0, illegal}, {31'd0, model_q[0].ill});
      end else if (post_rst) begin
        chk("rst_opdA", opdA, 32'd0);
        chk("rst_opdB", opdB, 32'd0);
        chk("rst_op_sel", {28'd0, op_sel}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    logic [4:0] rs1f, rs2f, rdf;
    logic [2:0] f3;
    int k;
    k    = $urandom_range(0, 9);
    rs1f = 5'($urandom_range(0, 7));
    rs2f = 5'($urandom_range(0, 7));
    rdf  = 5'($urandom_range(0, 31));
    f3   = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      3:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    if (k <= 3) return {f7, rs2f, rs1f, f3, rdf, 7'h33};
    if (k <= 6) begin
      if (f3 == 3'd1 || f3 == 3'd5) return {f7, rs2f, rs1f, f3, rdf, 7'h13};
      return {12'($urandom), rs1f, f3, rdf, 7'h13};
    end
    if (k == 7) return {20'($urandom), rdf, 7'h37};
    if (k == 8) return {20'($urandom), rdf, 7'h17};
    return $urandom;
  endfunction

  initial begin
    tick();
    tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_opdA", opdA, 32'd0);
    chk("reset_op_sel", {28'd0, op_sel}, 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    issue(32'h002081B3, 32'd5, 32'd7);
    tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_op", {28'd0, op_sel}, 32'(OpAdd));
    chk("add_opdA", opdA, 32'd5);
    chk("add_opdB", opdB, 32'd7);
    chk("add_rd", {27'd0, rd}, 32'd3);

    issue(32'h40435293, 32'h8000_0000, 32'd0);
    tick();
    chk("srai_op", {28'd0, op_sel}, 32'(OpSra));
    chk("srai_opdA", opdA, 32'h8000_0000);
    chk("srai_opdB", opdB, 32'd4);

    issue(32'hFFF00093, 32'd0, 32'd0);
    tick();
    chk("addi_op", {28'd0, op_sel}, 32'(OpAdd));
    chk("addi_opdB", opdB, 32'hFFFF_FFFF);
    chk("addi_rd", {27'd0, rd}, 32'd1);

    issue(32'h002081B3, 32'd0, 32'd7);
    fwd_en   = 1'b1;
    fwd_rd   = 5'd1;
    fwd_data = 32'h55;
    tick();
    chk("fwd_opdA", opdA, 32'h55);
    chk("fwd_opdB", opdB, 32'd7);

    issue(32'h002081B3, 32'h11, 32'd7);
    fwd_rd = 5'd0;
    tick();
    chk("fwd_x0_opdA", opdA, 32'h11);
    fwd_en = 1'b0;

    issue(32'h0000000B, 32'h1234, 32'h5678);
    tick();
    chk("custom_illegal", {31'd0, illegal}, 32'd1);
    chk("custom_opdA", opdA, 32'd0);
    chk("custom_opdB", opdB, 32'd0);
    chk("custom_rd", {27'd0, rd}, 32'd0);

    issue(32'h022081B3, 32'h1234, 32'h5678);
    tick();
    chk("f7_illegal", {31'd0, illegal}, 32'd1);
    chk("f7_rd", {27'd0, rd}, 32'd0);

    // Backpressure: fill both entries, hold, then drain.
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    issue(32'h002081B3, 32'd1, 32'd2);
    tick();
    chk("bp_i1_opdA", opdA, 32'd1);
    chk("bp_i1_in_ready", {31'd0, in_ready}, 32'd1);
    issue(32'h40435293, 32'd9, 32'd0);
    tick();
    chk("bp_two_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_two_opdA", opdA, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_hold_opdA", opdA, 32'd1);
    chk("bp_hold_op", {28'd0, op_sel}, 32'(OpAdd));
    out_ready = 1'b1;
    tick();
    chk("bp_i2_op", {28'd0, op_sel}, 32'(OpSra));
    chk("bp_i2_opdA", opdA, 32'd9);
    chk("bp_i2_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush, then reset, each hitting a full buffer with a same-cycle instruction.
    for (int pass = 0; pass < 2; pass++) begin
      out_ready = 1'b0;
      issue(32'h002081B3, 32'd3, 32'd4);
      tick();
      issue(32'h00208133, 32'd5, 32'd6);
      tick();
      chk("kill_full", {31'd0, in_ready}, 32'd0);
      issue(32'h002081B3, 32'd7, 32'd8);
      out_ready = 1'b1;
      if (pass == 0) flush = 1'b1;
      else rst = 1'b1;
      tick();
      flush    = 1'b0;
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("kill_out_valid", {31'd0, out_valid}, 32'd0);
      chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("kill_nothing", {31'd0, out_valid}, 32'd0);
    end

    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      fwd_en    = 1'($urandom_range(0, 1));
      fwd_rd    = 5'($urandom_range(0, 7));
      fwd_data  = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Register-to-ALU issue stage: accepts one RV32I instruction per cycle with its register-file read data and PC, decodes the ALU-class opcodes into `op_sel`, `opdA` and `opdB`, and presents them to the combinational ALU through a registered valid/ready output. Operand forwarding from writeback and a two-entry skid buffer keep the ALU input stable under backpressure. Sits directly upstream of the ALU; `rd` and `illegal` travel alongside for writeback.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage can accept; registered.
- `instr`  in  32  instruction word.
- `pc`  in  32  instruction address (AUIPC only).
- `rs1_data`, `rs2_data`  in  32 each  register-file read data for `instr[19:15]`, `instr[24:20]`.
- `fwd_en`  in  1  writeback result valid this cycle.
- `fwd_rd`  in  5  writeback destination.
- `fwd_data`  in  32  writeback value.
- `flush`  in  1  discard all held and incoming instructions.
- `out_valid`  out  1  ALU operands valid.
- `out_ready`  in  1  downstream consumes ALU result this cycle.
- `opdA`, `opdB`  out  32 each  ALU operands.
- `op_sel`  out  4  ALU operation, shared-header encoding.
- `rd`  out  5  destination register.
- `illegal`  out  1  instruction was not ALU-class.

## Operation
- Accept when `in_valid && in_ready && !rst && !flush`.
- Operand source: rs1 value = `fwd_data` if `fwd_en && fwd_rd != 0 && fwd_rd == instr[19:15]`, else `rs1_data`; same rule for rs2. Sampled at acceptance only.
- OP (0110011), funct3 0..7 -> ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. funct7 0100000 is legal only for ADD->SUB and SRL->SRA; any other funct7 except 0000000 is illegal. `opdA`=rs1, `opdB`=rs2.
- OP-IMM (0010011): same funct3 mapping without SUB; `opdB` = sign-extended `instr[31:20]`. SLLI requires funct7=0000000. SRLI/SRAI use funct7 0000000/0100000, anything else illegal; `opdB` = {27'b0, `instr[24:20]`}.
- LUI (0110111): ADD, `opdA`=0, `opdB`={`instr[31:12]`,12'b0}. AUIPC (0010111): ADD, `opdA`=`pc`, same `opdB`.
- Any other opcode, or an illegal funct combination: `illegal`=1, `op_sel`=ADD, `opdA`=`opdB`=0, `rd`=0. The instruction still flows through the handshake.
- `rd`=`instr[11:7]` for legal instructions. x0 is not suppressed here; writeback ignores it.
- Buffer states: EMPTY (no output entry); ONE (output entry only); TWO (output entry plus skid).
  - EMPTY + accept -> ONE.
  - ONE + accept + `out_ready` -> ONE, new entry replaces output.
  - ONE + accept + `!out_ready` -> TWO, new entry goes to skid.
  - ONE + `out_ready`, no accept -> EMPTY.
  - TWO + `out_ready` -> ONE, skid moves to output.
  - TWO + `!out_ready` -> TWO, hold.
- `in_ready` = 1 exactly when the state is not TWO; it is registered, so no combinational path from `out_ready`.
- Outputs are held bit-stable while `out_valid && !out_ready`.
- RAW hazards against instructions still in this stage or the ALU are the upstream hazard unit's responsibility.

## Timing
- Latency: instruction accepted at edge N is on the outputs with `out_valid`=1 from edge N until consumed (one cycle in-to-out). Throughput is 1 per cycle with `out_ready` held high.
- Reset (sync, highest priority): state EMPTY, `out_valid`=0, `in_ready`=1, `opdA`=`opdB`=0, `op_sel`=ADD, `rd`=0, `illegal`=0. Reset mid-operation drops both entries.
- `flush`: next state EMPTY and `out_valid`=0. A same-cycle `in_valid` is dropped, with `in_ready` staying or returning to 1 next cycle. A same-cycle `out_ready` has no effect on state.
- Simultaneous `fwd_en` and acceptance: forwarding wins over register-file data.

## Structure
- The shared header holds the `op_sel` encodings (already shared with the ALU) plus the new opcode constants (OP, OP_IMM, LUI, AUIPC) and the funct7 constants.
- Sub-module `alu_issue_decode`: purely combinational instruction -> {`op_sel`, operand selects, immediate, `illegal`}.
- The parent `alu_issue` holds forwarding muxes, both entry registers and the state machine.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, `out_ready`=1 -> next cycle `out_valid`=1, ADD, `opdA`=5, `opdB`=7, `rd`=3.
- `srai x5,x6,4` (0x40435293), rs1=0x80000000 -> SRA, `opdB`=4; `addi x1,x0,-1` -> ADD, `opdB`=0xFFFFFFFF.
- `fwd_en`=1, `fwd_rd`=1, `fwd_data`=0x55 while issuing `add x3,x1,x2` with `rs1_data`=0 -> `opdA`=0x55. With `fwd_rd`=0, `opdA` takes `rs1_data`.
- Backpressure: `out_ready`=0, issue I1 then I2 -> state TWO, `in_ready`=0, I1 held stable. Raise `out_ready` -> I2 appears next cycle and `in_ready`=1.
- Opcode 0x0000000B, and OP with funct7=0000001 -> `illegal`=1, operands 0, `rd`=0.
- `flush` asserted in state TWO together with `in_valid` -> next cycle `out_valid`=0, `in_ready`=1, nothing emitted. `rst` asserted mid-stream gives the same result.
